// File: rtl/rom_loader_pkg.sv
// Shared types and constants for the Hack ROM loader: FSM state encoding,
// host command bytes and reply bytes.
package rom_loader_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CNT_HI  = 4'd1,
    ST_CNT_LO  = 4'd2,
    ST_DAT_HI  = 4'd3,
    ST_DAT_LO  = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHK     = 4'd6,
    ST_TX      = 4'd7,
    ST_TX_WAIT = 4'd8,
    ST_DRAIN   = 4'd9
  } state_t;

  localparam logic [7:0] DEF_CMD_LOAD = 8'h4C;
  localparam logic [7:0] DEF_CMD_RUN  = 8'h52;
  localparam logic [7:0] DEF_CMD_STOP = 8'h53;
  localparam logic [7:0] DEF_RSP_OK   = 8'h4B;
  localparam logic [7:0] DEF_RSP_ERR  = 8'h45;

  // States in which the inter-byte timer is counting.
  function automatic logic is_timed(input state_t s);
    return (s == ST_CNT_HI) || (s == ST_CNT_LO) || (s == ST_DAT_HI) ||
           (s == ST_DAT_LO) || (s == ST_WRITE)  || (s == ST_CHK)    ||
           (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/rom_loader_timer.sv
// Inter-byte timeout: reloads on restart, counts down while running and
// flags the cycle in which TIMEOUT_CYCLES idle cycles have elapsed.
module loader_timer #(
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic CLK,
  input  logic i_reset_n,
  input  logic i_restart,
  input  logic i_run,
  output logic o_expired
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] remaining;

  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      remaining <= '0;
    end else if (i_restart) begin
      remaining <= TW'(TIMEOUT_CYCLES);
    end else if (i_run && remaining != '0) begin
      remaining <= remaining - TW'(1);
    end
  end

  // Fires on the last idle cycle so the owner reacts on that same edge.
  assign o_expired = i_run && !i_restart && (remaining == TW'(1));

endmodule

// File: rtl/rom_loader.sv
// UART-driven loader for the Hack program ROM plus CPU run/stop control.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte per load.
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         ROM_DEPTH      = 256,
  parameter int         TIMEOUT_CYCLES = 10_000_000,
  parameter logic [7:0] CMD_LOAD       = DEF_CMD_LOAD,
  parameter logic [7:0] CMD_RUN        = DEF_CMD_RUN,
  parameter logic [7:0] CMD_STOP       = DEF_CMD_STOP,
  parameter logic [7:0] RSP_OK         = DEF_RSP_OK,
  parameter logic [7:0] RSP_ERR        = DEF_RSP_ERR
) (
  input  logic        CLK,
  input  logic        i_reset_n,
  input  logic [7:0]  i_UART_byte,
  input  logic        i_UART_byte_ready,
  output logic [7:0]  o_UART_byte,
  output logic        o_UART_byte_ready,
  input  logic        i_UART_byte_sent,
  output logic [15:0] o_ROM_addr,
  output logic [15:0] o_ROM_data,
  output logic        o_ROM_write,
  output logic        o_mode,
  output logic        o_busy,
  output logic [3:0]  o_dbg_state
);

  // Handshakes: i_UART_byte_ready and i_UART_byte_sent are single-cycle
  // pulses with no back-pressure; o_UART_byte_ready pulses once per reply and
  // o_UART_byte is held until the matching i_UART_byte_sent.

  localparam logic [16:0] DEPTH_W = 17'(ROM_DEPTH);

  state_t      state;
  logic [7:0]  cnt_hi;
  logic [7:0]  dat_hi;
  logic [7:0]  hold_byte;
  logic        hold_valid;
  logic        drain_after;
  logic [15:0] n_words;
  logic [15:0] idx;
  logic [15:0] idx_next;
  logic [15:0] cnt_word;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic        tmr_run;
  logic        tmr_restart;
  logic        tmr_expired;
  logic        chk_ok;

`ifdef ROM_LOADER_CHECKSUM_EN
  localparam logic CHK_EN = 1'b1;
  logic [7:0] sum;

  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sum <= '0;
    end else if (state == ST_IDLE) begin
      sum <= '0;
    end else if (i_UART_byte_ready &&
                 (state == ST_CNT_HI || state == ST_CNT_LO ||
                  state == ST_DAT_HI || state == ST_DAT_LO)) begin
      sum <= sum + i_UART_byte;
    end
  end

  assign chk_ok = (i_UART_byte == sum);
`else
  localparam logic CHK_EN = 1'b0;
  assign chk_ok = 1'b0;
`endif

  assign tmr_run     = is_timed(state);
  assign tmr_restart = i_UART_byte_ready || !tmr_run;

  loader_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK       (CLK),
    .i_reset_n (i_reset_n),
    .i_restart (tmr_restart),
    .i_run     (tmr_run),
    .o_expired (tmr_expired)
  );

  // A byte parked during a reply takes priority over a fresh one in IDLE.
  assign cmd_valid = hold_valid || i_UART_byte_ready;
  assign cmd_byte  = hold_valid ? hold_byte : i_UART_byte;
  assign cnt_word  = {cnt_hi, i_UART_byte};
  assign idx_next  = idx + 16'd1;

  assign o_busy      = (state != ST_IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge CLK or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state             <= ST_IDLE;
      cnt_hi            <= '0;
      dat_hi            <= '0;
      hold_byte         <= '0;
      hold_valid        <= 1'b0;
      drain_after       <= 1'b0;
      n_words           <= '0;
      idx               <= '0;
      o_UART_byte       <= '0;
      o_UART_byte_ready <= 1'b0;
      o_ROM_addr        <= '0;
      o_ROM_data        <= '0;
      o_ROM_write       <= 1'b0;
      o_mode            <= 1'b0;
    end else begin
      o_UART_byte_ready <= 1'b0;
      o_ROM_write       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hold_valid) begin
            hold_valid <= i_UART_byte_ready;
            if (i_UART_byte_ready) hold_byte <= i_UART_byte;
          end
          if (cmd_valid) begin
            if (cmd_byte == CMD_LOAD) begin
              o_mode      <= 1'b0;
              idx         <= '0;
              drain_after <= 1'b0;
              state       <= ST_CNT_HI;
            end else if (cmd_byte == CMD_RUN) begin
              o_mode            <= 1'b1;
              o_UART_byte       <= RSP_OK;
              o_UART_byte_ready <= 1'b1;
              state             <= ST_TX;
            end else if (cmd_byte == CMD_STOP) begin
              o_mode            <= 1'b0;
              o_UART_byte       <= RSP_OK;
              o_UART_byte_ready <= 1'b1;
              state             <= ST_TX;
            end
          end
        end
        ST_CNT_HI: begin
          if (i_UART_byte_ready) begin
            cnt_hi <= i_UART_byte;
            state  <= ST_CNT_LO;
          end else if (tmr_expired) begin
            o_UART_byte       <= RSP_ERR;
            o_UART_byte_ready <= 1'b1;
            state             <= ST_TX;
          end
        end
        ST_CNT_LO: begin
          if (i_UART_byte_ready) begin
            n_words <= cnt_word;
            if (cnt_word == 16'd0) begin
              if (CHK_EN) begin
                state <= ST_CHK;
              end else begin
                o_UART_byte       <= RSP_OK;
                o_UART_byte_ready <= 1'b1;
                state             <= ST_TX;
              end
            end else if ({1'b0, cnt_word} > DEPTH_W) begin
              o_UART_byte       <= RSP_ERR;
              o_UART_byte_ready <= 1'b1;
              drain_after       <= 1'b1;
              state             <= ST_TX;
            end else begin
              state <= ST_DAT_HI;
            end
          end else if (tmr_expired) begin
            o_UART_byte       <= RSP_ERR;
            o_UART_byte_ready <= 1'b1;
            state             <= ST_TX;
          end
        end
        ST_DAT_HI: begin
          if (i_UART_byte_ready) begin
            dat_hi <= i_UART_byte;
            state  <= ST_DAT_LO;
          end else if (tmr_expired) begin
            o_UART_byte       <= RSP_ERR;
            o_UART_byte_ready <= 1'b1;
            state             <= ST_TX;
          end
        end
        ST_DAT_LO: begin
          if (i_UART_byte_ready) begin
            o_ROM_write <= 1'b1;
            o_ROM_addr  <= idx;
            o_ROM_data  <= {dat_hi, i_UART_byte};
            state       <= ST_WRITE;
          end else if (tmr_expired) begin
            o_UART_byte       <= RSP_ERR;
            o_UART_byte_ready <= 1'b1;
            state             <= ST_TX;
          end
        end
        ST_WRITE: begin
          idx <= idx_next;
          if (idx_next == n_words) begin
            if (CHK_EN) begin
              state <= ST_CHK;
            end else begin
              o_UART_byte       <= RSP_OK;
              o_UART_byte_ready <= 1'b1;
              state             <= ST_TX;
            end
          end else begin
            state <= ST_DAT_HI;
          end
        end
        ST_CHK: begin
          if (i_UART_byte_ready || tmr_expired) begin
            o_UART_byte       <= (i_UART_byte_ready && chk_ok) ? RSP_OK : RSP_ERR;
            o_UART_byte_ready <= 1'b1;
            state             <= ST_TX;
          end
        end
        ST_TX, ST_TX_WAIT: begin
          // Bytes heading into DRAIN are garbage from the rejected frame.
          if (i_UART_byte_ready && !drain_after) begin
            hold_byte  <= i_UART_byte;
            hold_valid <= 1'b1;
          end
          if (state == ST_TX) begin
            state <= ST_TX_WAIT;
          end else if (i_UART_byte_sent) begin
            state <= drain_after ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (tmr_expired) begin
            drain_after <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
